// File: rtl/demux_dispatcher_if.sv
// demux_dispatcher_if: producer stream, channel mask and demux-side bundle.
// slave: dispatcher view; master: producer/consumer view.
interface demux_dispatcher_if #(
    parameter int DATA_W = 1
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [15:0]       ch_en;
    logic [15:0]       out_ready;
    logic [3:0]        sel;
    logic [DATA_W-1:0] out_data;
    logic [15:0]       out_valid;
    logic              wrap;

    modport slave (
        input  in_valid, in_data, ch_en, out_ready,
        output in_ready, sel, out_data, out_valid, wrap
    );

    modport master (
        output in_valid, in_data, ch_en, out_ready,
        input  in_ready, sel, out_data, out_valid, wrap
    );
endinterface

// File: rtl/demux_dispatcher.sv
// demux_dispatcher: round-robin steering of a valid/ready stream onto a 1-to-16 demux.
// Ports: clk, rst (sync, active-high), bus (slave: in_*, ch_en, out_ready, sel, out_data, out_valid, wrap).
module demux_dispatcher #(
    parameter int DATA_W = 1
) (
    input logic                clk,
    input logic                rst,
    demux_dispatcher_if.slave  bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        sel_q, sel_d;
    logic [3:0]        ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              wrap_q, wrap_d;
    logic              first_q, first_d;

    logic [3:0] pick;
    logic [3:0] idx;
    logic       found;
    logic       accept;
    logic       drain;

    // First enabled channel at or after ptr, wrapping modulo 16.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < 16; k++) begin
            idx = ptr_q + k[3:0];
            if (!found && bus.ch_en[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    assign bus.in_ready = !rst && (|bus.ch_en) &&
                          (state_q == EMPTY || bus.out_ready[sel_q]);
    assign accept = bus.in_valid & bus.in_ready;
    assign drain  = (state_q == FULL) & bus.out_ready[sel_q];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        wrap_d  = wrap_q;
        first_d = first_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (drain && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            // sel_q still holds the previous beat's channel here.
            wrap_d  = !first_q && (pick <= sel_q);
            sel_d   = pick;
            ptr_d   = pick + 4'd1;
            data_d  = bus.in_data;
            first_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            sel_q   <= 4'd0;
            ptr_q   <= 4'd0;
            data_q  <= '0;
            wrap_q  <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            wrap_q  <= wrap_d;
            first_q <= first_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = (state_q == FULL) ? (16'h0001 << sel_q) : 16'h0000;
    assign bus.wrap      = wrap_q & (state_q == FULL);
endmodule

// File: tb/tb_demux_dispatcher.sv
// tb_demux_dispatcher: directed literal checks plus randomized run against a
// behavioural round-robin model.
module tb_demux_dispatcher;
    localparam int DATA_W = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_dispatcher_if #(.DATA_W(DATA_W)) bus ();

    demux_dispatcher #(.DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    bit              m_pend;
    int              m_sel;
    int              m_ptr;
    logic [DATA_W-1:0] m_data;
    bit              m_wrap;
    bit              m_first;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit rdy;
        int j;
        bit got;
        if (rst) begin
            m_pend  = 0;
            m_sel   = 0;
            m_ptr   = 0;
            m_data  = '0;
            m_wrap  = 0;
            m_first = 1;
        end else begin
            rdy = (bus.ch_en != 16'h0) && (!m_pend || bus.out_ready[m_sel]);
            if (m_pend && bus.out_ready[m_sel]) m_pend = 0;
            if (bus.in_valid && rdy) begin
                got = 0;
                j = 0;
                for (int k = 0; k < 16; k++) begin
                    if (!got && bus.ch_en[(m_ptr + k) % 16]) begin
                        got = 1;
                        j = (m_ptr + k) % 16;
                    end
                end
                m_wrap  = !m_first && (j <= m_sel);
                m_sel   = j;
                m_ptr   = (j + 1) % 16;
                m_data  = bus.in_data;
                m_first = 0;
                m_pend  = 1;
            end
        end
    end

    always @(negedge clk) begin
        bit er;
        if (chk_en) begin
            er = !rst && (bus.ch_en != 16'h0) &&
                 (!m_pend || bus.out_ready[m_sel]);
            check("m_in_ready", 32'(bus.in_ready), 32'(er));
            check("m_sel", 32'(bus.sel), 32'(m_sel));
            check("m_out_valid", 32'(bus.out_valid),
                  m_pend ? (32'h1 << m_sel) : 32'h0);
            check("m_out_data", 32'(bus.out_data), 32'(m_data));
            check("m_wrap", 32'(bus.wrap), 32'(m_pend && m_wrap));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.ch_en     = 16'hFFFF;
        bus.out_ready = 16'hFFFF;

        // Reset then idle
        @(posedge clk);
        #1;
        do_reset();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_sel", 32'(bus.sel), 32'h0);
        check("rst_wrap", 32'(bus.wrap), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        tick();

        // Full sweep
        bus.in_valid = 1'b1;
        bus.in_data  = 1'b1;
        for (int b = 0; b < 17; b++) begin
            @(posedge clk);
            #1;
            if (b == 16) bus.in_valid = 1'b0;
            @(negedge clk);
            check("sweep_sel", 32'(bus.sel), 32'(b % 16));
            check("sweep_valid", 32'(bus.out_valid), 32'h1 << (b % 16));
            check("sweep_wrap", 32'(bus.wrap), 32'(b == 16));
        end
        tick();

        // Mask skip
        do_reset();
        bus.ch_en    = 16'h8421;
        bus.in_valid = 1'b1;
        for (int b = 0; b < 5; b++) begin
            @(posedge clk);
            #1;
            if (b == 4) bus.in_valid = 1'b0;
            @(negedge clk);
            check("skip_sel", 32'(bus.sel), 32'((b * 5) % 20));
            check("skip_wrap", 32'(bus.wrap), 32'(b == 4));
        end
        tick();

        // Backpressure on channel 3
        do_reset();
        bus.ch_en     = 16'h0008;
        bus.out_ready = 16'h0000;
        bus.in_valid  = 1'b1;
        bus.in_data   = 1'b1;
        tick();
        bus.in_data = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 32'h0);
            check("bp_sel", 32'(bus.sel), 32'h3);
            check("bp_data", 32'(bus.out_data), 32'h1);
            check("bp_valid", 32'(bus.out_valid), 32'h0008);
            tick();
        end
        bus.out_ready = 16'h0008;
        @(negedge clk);
        check("bp_release_ready", 32'(bus.in_ready), 32'h1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_sel", 32'(bus.sel), 32'h3);
        check("bp_next_data", 32'(bus.out_data), 32'h0);
        check("bp_next_wrap", 32'(bus.wrap), 32'h1);
        check("bp_next_valid", 32'(bus.out_valid), 32'h0008);
        tick();

        // Mask change while pending
        do_reset();
        bus.ch_en     = 16'h0004;
        bus.out_ready = 16'h0000;
        bus.in_valid  = 1'b1;
        bus.in_data   = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.ch_en    = 16'hFFFB;
        @(negedge clk);
        check("mc_sel", 32'(bus.sel), 32'h2);
        check("mc_valid", 32'(bus.out_valid), 32'h0004);
        tick();
        @(negedge clk);
        check("mc_hold_valid", 32'(bus.out_valid), 32'h0004);
        bus.ch_en     = 16'h0000;
        bus.out_ready = 16'hFFFF;
        #1;
        check("mc_zero_ready", 32'(bus.in_ready), 32'h0);
        tick();
        @(negedge clk);
        check("mc_drained", 32'(bus.out_valid), 32'h0);
        tick();
        bus.ch_en    = 16'h0003;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mc_skip_sel", 32'(bus.sel), 32'h0);
        check("mc_skip_wrap", 32'(bus.wrap), 32'h1);
        tick();

        // Reset mid-operation
        do_reset();
        bus.ch_en     = 16'h0080;
        bus.out_ready = 16'h0000;
        bus.in_valid  = 1'b1;
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rm_in_ready", 32'(bus.in_ready), 32'h0);
        check("rm_sel_before", 32'(bus.sel), 32'h7);
        tick();
        rst          = 1'b0;
        bus.ch_en    = 16'hFFFF;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rm_valid", 32'(bus.out_valid), 32'h0);
        check("rm_sel", 32'(bus.sel), 32'h0);
        tick();
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("rm_next_sel", 32'(bus.sel), 32'h0);
        check("rm_next_wrap", 32'(bus.wrap), 32'h0);
        check("rm_next_valid", 32'(bus.out_valid), 32'h0001);
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 99) == 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_data  = DATA_W'($urandom);
            case ($urandom_range(0, 3))
                0: bus.ch_en = 16'hFFFF;
                1: bus.ch_en = 16'($urandom);
                2: bus.ch_en = 16'h1 << $urandom_range(0, 15);
                default: bus.ch_en = ($urandom_range(0, 7) == 0) ? 16'h0 :
                                     (16'($urandom) & 16'($urandom));
            endcase
            bus.out_ready = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'($urandom);
            tick();
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
